spi_slave_device: RTL and testbench

SPI_SLAVE_DEVICE -- requirements
Module: spi_slave_device

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_slave_device_if.sv | 32 +++
 rtl/spi_rx_fifo.sv | 50 +++++
 rtl/spi_slave_device.sv | 212 +++++++++++++++++++++
 tb/tb_spi_slave_device.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave device.
// Mode encoding is {CPOL,CPHA}; states follow the slave frame sequence.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    PUSH  = 2'd3
  } slave_state_t;

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic [1:0] m);
    return (m[1] == m[0]);
  endfunction

endpackage

// File: rtl/spi_slave_device_if.sv
// Pin and host-side bundle of the SPI slave device.
// The slave modport is the device view; the master modport drives it.
interface spi_slave_device_if;
  import spi_pkg::*;

  logic [1:0]            mode;
  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [SPI_DATA_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_overflow;
  logic                  ovf_clr;
  logic                  busy;

  modport slave (
    input  mode, cs, sclk, mosi, tx_data, tx_valid, rx_ready, ovf_clr,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overflow, busy
  );

  modport master (
    output mode, cs, sclk, mosi, tx_data, tx_valid, rx_ready, ovf_clr,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overflow, busy
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry an extra wrap bit for full/empty.
// A write into a full FIFO is allowed only when a read retires an entry in the same cycle.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  Pclk,
  input  logic                  Preset,
  input  logic                  wr_en,
  input  logic [SPI_DATA_W-1:0] wr_data,
  input  logic                  rd_en,
  output logic [SPI_DATA_W-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [SPI_DATA_W-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_rd;
  logic                  do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign drop    = wr_en && full && !do_rd;
  // Empty FIFO presents zero so rx_data is defined straight out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge Pclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_slave_device.sv
// SPI slave with TX holding register and RX FIFO, oversampled on Pclk.
// Optional macro SPI_SLAVE_ECHO_EN: an empty holding register sends the last received byte.
//
// state | meaning
// IDLE  | waiting for synchronized cs falling edge
// LOAD  | first TX byte copied into the shifter
// SHIFT | bits moving on sample/shift edges
// PUSH  | received byte written to FIFO, next TX byte loaded
module spi_slave_device
  import spi_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [SPI_DATA_W-1:0] IDLE_BYTE  = 8'hFF
) (
  input logic               Pclk,
  input logic               Preset,
  spi_slave_device_if.slave bus
);

  slave_state_t state, state_nx;

  logic cs_meta, cs_s, cs_d;
  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;
  logic cs_fall, sclk_rise, sclk_fall;

  logic [1:0]            mode_q;
  logic                  cpha;
  logic                  sample_edge;
  logic                  shift_edge;
  logic [2:0]            bit_cnt;
  logic [SPI_DATA_W-1:0] rx_shift;
  logic [SPI_DATA_W-1:0] tx_shift;
  logic                  miso_q;

  logic [SPI_DATA_W-1:0] hold_q;
  logic                  hold_full;
  logic                  tx_accept;
  logic [SPI_DATA_W-1:0] fill_byte;
  logic [SPI_DATA_W-1:0] load_byte;

  logic                  load_tx;
  logic                  push_en;
  logic                  busy_c;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_drop;
  logic                  ovf_q;

  // sclk synchronizer idles at the CPOL present while reset is held.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      cs_d      <= 1'b1;
      sclk_meta <= bus.mode[1];
      sclk_s    <= bus.mode[1];
      sclk_d    <= bus.mode[1];
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      cs_meta   <= bus.cs;
      cs_s      <= cs_meta;
      cs_d      <= cs_s;
      sclk_meta <= bus.sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      mosi_meta <= bus.mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign cs_fall   = cs_d & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // Mode is frozen for the whole frame; it only follows the pin while idle and deselected.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      mode_q <= 2'b00;
    end else if (state == IDLE && cs_s) begin
      mode_q <= bus.mode;
    end
  end

  assign cpha        = mode_q[0];
  assign sample_edge = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;
  assign shift_edge  = sample_on_rise(mode_q) ? sclk_fall : sclk_rise;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_tx  = 1'b0;
    push_en  = 1'b0;
    busy_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nx = LOAD;
      end
      LOAD: begin
        load_tx  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cs_s)                               state_nx = IDLE;
        else if (sample_edge && bit_cnt == 3'd7) state_nx = PUSH;
      end
      PUSH: begin
        load_tx  = 1'b1;
        push_en  = 1'b1;
        state_nx = cs_s ? IDLE : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_ECHO_EN
  logic [SPI_DATA_W-1:0] echo_q;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset)       echo_q <= IDLE_BYTE;
    else if (push_en) echo_q <= rx_shift;
  end

  // In PUSH the byte just assembled is already the most recent one received.
  assign fill_byte = push_en ? rx_shift : echo_q;
`else
  assign fill_byte = IDLE_BYTE;
`endif

  assign load_byte = hold_full ? hold_q : fill_byte;
  assign tx_accept = bus.tx_valid & ~hold_full;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (tx_accept) begin
      hold_q    <= bus.tx_data;
      hold_full <= 1'b1;
    end else if (load_tx) begin
      hold_full <= 1'b0;
    end
  end

  // CPHA=0 shifts only after a sample in this byte, so the MSB loaded in PUSH survives
  // the trailing edge of the previous byte.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_q   <= 1'b0;
    end else if (load_tx) begin
      bit_cnt <= '0;
      if (cpha) begin
        tx_shift <= load_byte;
        if (state == LOAD) miso_q <= 1'b0;
      end else begin
        miso_q   <= load_byte[SPI_DATA_W-1];
        tx_shift <= {load_byte[SPI_DATA_W-2:0], 1'b0};
      end
    end else if (state == SHIFT) begin
      if (cs_s) begin
        bit_cnt <= '0;
      end else begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[SPI_DATA_W-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (shift_edge && (cpha || bit_cnt != 3'd0)) begin
          miso_q   <= tx_shift[SPI_DATA_W-1];
          tx_shift <= {tx_shift[SPI_DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .Pclk    (Pclk),
    .Preset  (Preset),
    .wr_en   (push_en),
    .wr_data (rx_shift),
    .rd_en   (bus.rx_ready),
    .rd_data (bus.rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset)           ovf_q <= 1'b0;
    else if (fifo_drop)   ovf_q <= 1'b1;
    else if (bus.ovf_clr) ovf_q <= 1'b0;
  end

  assign bus.miso        = miso_q & ~cs_s;
  assign bus.miso_oe     = ~cs_s;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_valid    = ~fifo_empty & ~fifo_full | fifo_full;
  assign bus.rx_overflow = ovf_q;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_spi_slave_device.sv
// Directed and randomized bench for spi_slave_device acting as SPI master.
// Expected bytes come from a queue model of the FIFO and per-byte TX plan.
module tb_spi_slave_device;
  import spi_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [7:0]  IDLE_B = 8'hFF;
  localparam int          H      = 6;

  logic Pclk = 1'b0;
  logic Preset;

  spi_slave_device_if bus();

  spi_slave_device #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_BYTE  (IDLE_B)
  ) dut (
    .Pclk   (Pclk),
    .Preset (Preset),
    .bus    (bus)
  );

  always #5 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic       ovf_m;
  logic [7:0] last_rx;
  logic       cpol, cpha;

  logic [7:0] f_mosi[8];
  logic [7:0] f_tx[8];
  bit         f_stg[8];
  int         f_n;
  bit         f_pop, f_clr, cur_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Pclk);
  endtask

  function automatic logic [7:0] fill_byte();
`ifdef SPI_SLAVE_ECHO_EN
    return last_rx;
`else
    return IDLE_B;
`endif
  endfunction

  task automatic model_reset();
    rx_q.delete();
    ovf_m   = 1'b0;
    last_rx = IDLE_B;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (f_pop && rx_q.size() > 0) void'(rx_q.pop_front());
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else                     ovf_m = 1'b1;
    if (f_clr && rx_q.size() < DEPTH && !ovf_m) ovf_m = 1'b0;
    last_rx = b;
  endtask

  task automatic check_reset_outputs();
    chk("rst_miso", bus.miso, 0);
    chk("rst_miso_oe", bus.miso_oe, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_overflow", bus.rx_overflow, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.mode = m;
    cpol     = m[1];
    cpha     = m[0];
    bus.sclk = cpol;
    cyc(4);
  endtask

  task automatic stage(input logic [7:0] d);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("tx_ready_wait", bus.tx_ready, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  // Runs across the half period after the 8th sample edge; PUSH is the first cycle with busy low.
  task automatic push_window();
    bit seen = 0;
    bit pend = 0;
    for (int c = 0; c < H; c++) begin
      cyc(1);
      bus.rx_ready = 1'b0;
      bus.ovf_clr  = 1'b0;
      if (pend) begin
        chk("rx_valid_after_push", bus.rx_valid, 1);
        pend = 0;
      end
      if (!seen && bus.busy === 1'b0) begin
        seen = 1;
        if (cur_lat) begin
          chk("rx_valid_in_push", bus.rx_valid, 0);
          pend = 1;
        end
        if (f_pop) bus.rx_ready = 1'b1;
        if (f_clr) bus.ovf_clr  = 1'b1;
      end
    end
    bus.rx_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    chk("push_seen", seen, 1);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        bus.mosi = tx[7-i];
        cyc(H);
        if (i == 3) chk("busy_mid", bus.busy, 1);
        bus.sclk = ~cpol;
        rx = {rx[6:0], bus.miso};
        if (i == 7) push_window();
        else        cyc(H);
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = tx[7-i];
        cyc(H);
        if (i == 3) chk("busy_mid", bus.busy, 1);
        bus.sclk = cpol;
        rx = {rx[6:0], bus.miso};
        if (i == 7) push_window();
        else        cyc(H);
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input bit scramble);
    logic [7:0] exp_b;
    logic [7:0] got_b;
    set_mode(m);
    if (f_stg[0]) stage(f_tx[0]);
    bus.cs = 1'b0;
    cyc(8);
    if (scramble) bus.mode = 2'($urandom_range(0, 3));
    for (int k = 0; k < f_n; k++) begin
      if (k + 1 < f_n && f_stg[k+1]) stage(f_tx[k+1]);
      exp_b   = f_stg[k] ? f_tx[k] : fill_byte();
      cur_lat = (rx_q.size() == 0);
      xfer(f_mosi[k], 8, got_b);
      chk("miso_byte", got_b, exp_b);
      model_push(f_mosi[k]);
    end
    cyc(H);
    bus.cs = 1'b1;
    cyc(8);
    f_pop = 0;
    f_clr = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (rx_q.size() > 0 && n < 2 * DEPTH) begin
      chk("rx_valid", bus.rx_valid, 1);
      chk("rx_data", bus.rx_data, rx_q[0]);
      bus.rx_ready = 1'b1;
      cyc(1);
      bus.rx_ready = 1'b0;
      void'(rx_q.pop_front());
      n++;
    end
    chk("rx_drained", bus.rx_valid, 0);
  endtask

  task automatic clear_ovf();
    bus.ovf_clr = 1'b1;
    cyc(1);
    bus.ovf_clr = 1'b0;
    ovf_m = 1'b0;
  endtask

  task automatic one_byte(input logic [7:0] mo, input bit stg, input logic [7:0] tx);
    f_n       = 1;
    f_mosi[0] = mo;
    f_stg[0]  = stg;
    f_tx[0]   = tx;
  endtask

  initial begin
    logic [7:0] junk;
    bus.cs       = 1'b1;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.mode     = 2'b00;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    f_pop = 0;
    f_clr = 0;
    cpol  = 0;
    cpha  = 0;
    model_reset();
    Preset = 1'b1;
    cyc(3);
    check_reset_outputs();
    Preset = 1'b0;
    cyc(4);
    check_reset_outputs();

    // Mode 0 with a staged byte.
    one_byte(8'h3C, 1, 8'hA5);
    run_frame(2'd0, 0);
    chk("rx_data_3c", bus.rx_data, 8'h3C);
    drain();

    // Modes 1..3 with nothing staged.
    for (int m = 1; m < 4; m++) begin
      one_byte(8'h81, 0, 8'h00);
      run_frame(2'(m), 0);
      chk("rx_data_81", bus.rx_data, 8'h81);
      drain();
    end

    // Five bytes into a four-entry FIFO.
    f_n = 5;
    for (int k = 0; k < 5; k++) begin
      f_mosi[k] = 8'(k + 1);
      f_stg[k]  = 0;
    end
    run_frame(2'd0, 0);
    chk("ovf_set", bus.rx_overflow, 1);
    chk("ovf_model", bus.rx_overflow, ovf_m);
    clear_ovf();
    chk("ovf_cleared", bus.rx_overflow, 0);

    // Drop coinciding with ovf_clr: the set wins.
    one_byte(8'h77, 0, 8'h00);
    f_clr = 1;
    run_frame(2'd1, 0);
    chk("ovf_set_wins", bus.rx_overflow, 1);
    clear_ovf();

    // Push and pop together when full: no overflow.
    one_byte(8'h66, 1, 8'h42);
    f_pop = 1;
    run_frame(2'd2, 0);
    chk("full_push_pop_ovf", bus.rx_overflow, 0);
    drain();

    // Frame aborted after five bits.
    set_mode(2'd0);
    bus.cs = 1'b0;
    cyc(8);
    xfer(8'hF0, 5, junk);
    cyc(H);
    bus.cs = 1'b1;
    cyc(8);
    chk("abort_rx_valid", bus.rx_valid, 0);
    chk("abort_busy", bus.busy, 0);
    one_byte(8'h5A, 0, 8'h00);
    run_frame(2'd0, 0);
    chk("after_abort_5a", bus.rx_data, 8'h5A);
    drain();

    // Randomized frames, mode pin disturbed mid-frame.
    for (int r = 0; r < 12; r++) begin
      f_n = $urandom_range(1, 3);
      for (int k = 0; k < 8; k++) begin
        f_mosi[k] = 8'($urandom);
        f_tx[k]   = 8'($urandom);
        f_stg[k]  = bit'($urandom_range(0, 1));
      end
      f_pop = ($urandom_range(0, 3) == 0);
      run_frame(2'($urandom_range(0, 3)), 1);
      chk("rand_ovf", bus.rx_overflow, ovf_m);
      chk("rand_rx_valid", bus.rx_valid, rx_q.size() > 0);
      if ($urandom_range(0, 1) == 1) drain();
      if (ovf_m && $urandom_range(0, 1) == 1) clear_ovf();
    end

    // Leave data and overflow pending, then reset mid-frame.
    f_n = 5;
    for (int k = 0; k < 5; k++) begin
      f_mosi[k] = 8'($urandom);
      f_stg[k]  = 0;
    end
    run_frame(2'd1, 0);
    set_mode(2'd3);
    bus.cs = 1'b0;
    cyc(8);
    stage(8'h99);
    xfer(8'h5F, 3, junk);
    Preset = 1'b1;
    #1;
    check_reset_outputs();
    bus.cs   = 1'b1;
    bus.sclk = cpol;
    cyc(2);
    Preset = 1'b0;
    model_reset();
    cyc(4);
    check_reset_outputs();
    one_byte(8'hC3, 0, 8'h00);
    run_frame(2'd3, 0);
    chk("after_reset_c3", bus.rx_data, 8'hC3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
